// File: rtl/piso_serializer_if.sv
// piso_serializer_if: parallel word load handshake between a sample producer and the serializer
interface piso_serializer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    modport master (output data_in, output data_valid, input data_ready);
    modport slave (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parameterised parallel-in/serial-out word serializer with valid/ready load,
// divided bit clock and frame strobe; gapless when a new word is offered on the last bit cycle.
module piso_serializer #(
    parameter int WIDTH      = 32,
    parameter int CLK_DIV    = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    piso_serializer_if.slave  load,
    output logic              serial_out,
    output logic              sclk,
    output logic              frame,
    output logic              word_done
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [BIT_W-1:0] bit_cnt, bit_n;
    logic             serial_n, sclk_n, frame_n;
    logic             last, accept;

    assign last            = state == SHIFT && bit_cnt == BIT_LAST && div_cnt == DIV_LAST;
    assign load.data_ready = state == IDLE || last;
    assign word_done       = last;
    assign accept          = load.data_valid && load.data_ready;

    // Serial outputs are registered from next-state values so they line up with the counters.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        if (accept) begin
            state_n = SHIFT;
            shreg_n = load.data_in;
            div_n   = '0;
            bit_n   = '0;
        end else if (state == SHIFT) begin
            div_n = div_cnt == DIV_LAST ? '0 : div_cnt + 1'b1;
            if (div_cnt == DIV_LAST) begin
                bit_n   = bit_cnt + 1'b1;
                shreg_n = MSB_FIRST ? shreg << 1 : shreg >> 1;
            end
            if (last) state_n = IDLE;
        end
        serial_n = state_n == SHIFT ? (MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0]) : IDLE_LEVEL;
        sclk_n   = state_n == SHIFT && div_n >= DIV_HALF;
        frame_n  = state_n == SHIFT;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            serial_out <= IDLE_LEVEL;
            sclk       <= 1'b0;
            frame      <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            div_cnt    <= div_n;
            bit_cnt    <= bit_n;
            serial_out <= serial_n;
            sclk       <= sclk_n;
            frame      <= frame_n;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: randomized self-checking bench; expected streams come from a word/bit-position model.
module tb_piso_serializer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    piso_serializer_if #(.WIDTH(32)) ia ();
    piso_serializer_if #(.WIDTH(8))  ib ();
    logic so_a, sclk_a, frame_a, done_a;
    logic so_b, sclk_b, frame_b, done_b;

    piso_serializer #(.WIDTH(32), .CLK_DIV(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .clock(clock), .reset_n(reset_n), .load(ia.slave),
        .serial_out(so_a), .sclk(sclk_a), .frame(frame_a), .word_done(done_a)
    );
    piso_serializer #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
        .clock(clock), .reset_n(reset_n), .load(ib.slave),
        .serial_out(so_b), .sclk(sclk_b), .frame(frame_b), .word_done(done_b)
    );

    int checks = 0;
    int errors = 0;

    // Bit j-th cycle of a frame carries word bit (j / div), counted from the head end.
    function automatic logic ref_bit(input logic [31:0] w, input int width, input int div, input bit msb, input int j);
        int b;
        b = j / div;
        return msb ? w[width-1-b] : w[b];
    endfunction

    function automatic logic ref_sclk(input int div, input int j);
        return (j % div) >= div / 2;
    endfunction

    task automatic test_reset();
        logic [4:0] got;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ia.data_in = $urandom;
            ia.data_valid = 1'($urandom_range(0, 1));
            ib.data_in = 8'($urandom);
            ib.data_valid = 1'($urandom_range(0, 1));
            @(negedge clock);
            got = {ia.data_ready, frame_a, sclk_a, so_a, done_a};
            checks++;
            if (got !== 5'b10000) begin
                errors++;
                $display("FAIL reset_a cycle=%0d got %b exp %b", i, got, 5'b10000);
            end
            got = {ib.data_ready, frame_b, sclk_b, so_b, done_b};
            checks++;
            if (got !== 5'b10010) begin
                errors++;
                $display("FAIL reset_b cycle=%0d got %b exp %b", i, got, 5'b10010);
            end
        end
        ia.data_valid = 1'b0;
        ib.data_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        got = {ia.data_ready, frame_a, sclk_a, so_a, done_a};
        checks++;
        if (got !== 5'b10000) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", got, 5'b10000);
        end
    endtask

    task automatic test_single_word();
        logic [31:0] w = 32'hA500_0001;
        logic [4:0] got, exp;
        logic prev = 1'b0;
        int rises = 0;
        int frames = 0;
        ia.data_in = w;
        ia.data_valid = 1'b1;
        for (int j = 0; j < 128; j++) begin
            @(negedge clock);
            if (j == 0) begin
                ia.data_valid = 1'b0;
                ia.data_in = $urandom;
            end
            if (sclk_a && !prev) rises++;
            prev = sclk_a;
            if (frame_a) frames++;
            got = {frame_a, sclk_a, so_a, done_a, ia.data_ready};
            exp = {1'b1, ref_sclk(4, j), ref_bit(w, 32, 4, 1'b1, j), j == 127, j == 127};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single_word j=%0d got %b exp %b", j, got, exp);
            end
        end
        @(negedge clock);
        checks++;
        if (rises !== 32) begin
            errors++;
            $display("FAIL single_sclk_rises got %0d exp 32", rises);
        end
        checks++;
        if (frames !== 128) begin
            errors++;
            $display("FAIL single_frame_len got %0d exp 128", frames);
        end
        got = {ia.data_ready, frame_a, sclk_a, so_a, done_a};
        checks++;
        if (got !== 5'b10000) begin
            errors++;
            $display("FAIL single_idle got %b exp %b", got, 5'b10000);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[2];
        logic [4:0] got, exp;
        int dones = 0;
        int frames = 0;
        int k, jj;
        w[0] = 32'hFFFF_0000;
        w[1] = 32'h0000_FFFF;
        ia.data_in = w[0];
        ia.data_valid = 1'b1;
        for (int j = 0; j < 256; j++) begin
            @(negedge clock);
            if (j == 0) ia.data_in = w[1];
            if (j == 128) ia.data_valid = 1'b0;
            k = j / 128;
            jj = j % 128;
            if (done_a) dones++;
            if (frame_a) frames++;
            got = {frame_a, sclk_a, so_a, done_a, ia.data_ready};
            exp = {1'b1, ref_sclk(4, jj), ref_bit(w[k], 32, 4, 1'b1, jj), jj == 127, jj == 127};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back j=%0d got %b exp %b", j, got, exp);
            end
        end
        @(negedge clock);
        checks++;
        if (dones !== 2) begin
            errors++;
            $display("FAIL b2b_done_count got %0d exp 2", dones);
        end
        checks++;
        if (frames !== 256) begin
            errors++;
            $display("FAIL b2b_frame_len got %0d exp 256", frames);
        end
        got = {ia.data_ready, frame_a, sclk_a, so_a, done_a};
        checks++;
        if (got !== 5'b10000) begin
            errors++;
            $display("FAIL b2b_idle got %b exp %b", got, 5'b10000);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        logic [4:0] got, exp;
        for (int n = 0; n < 4; n++) begin
            w = n == 0 ? 8'h01 : 8'($urandom);
            ib.data_in = w;
            ib.data_valid = 1'b1;
            for (int j = 0; j < 16; j++) begin
                @(negedge clock);
                if (j == 0) begin
                    ib.data_valid = 1'b0;
                    ib.data_in = 8'($urandom);
                end
                got = {frame_b, sclk_b, so_b, done_b, ib.data_ready};
                exp = {1'b1, ref_sclk(2, j), ref_bit(32'(w), 8, 2, 1'b0, j), j == 15, j == 15};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL lsb_first word=%h j=%0d got %b exp %b", w, j, got, exp);
                end
            end
            @(negedge clock);
            got = {ib.data_ready, frame_b, sclk_b, so_b, done_b};
            checks++;
            if (got !== 5'b10010) begin
                errors++;
                $display("FAIL lsb_idle word=%h got %b exp %b", w, got, 5'b10010);
            end
        end
    endtask

    task automatic test_mid_word_noise();
        logic [31:0] w;
        logic [4:0] got, exp;
        for (int n = 0; n < 3; n++) begin
            w = $urandom;
            ia.data_in = w;
            ia.data_valid = 1'b1;
            for (int j = 0; j < 128; j++) begin
                @(negedge clock);
                ia.data_in = $urandom;
                ia.data_valid = j == 127 ? 1'b0 : 1'($urandom_range(0, 1));
                got = {frame_a, sclk_a, so_a, done_a, ia.data_ready};
                exp = {1'b1, ref_sclk(4, j), ref_bit(w, 32, 4, 1'b1, j), j == 127, j == 127};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL noise word=%h j=%0d got %b exp %b", w, j, got, exp);
                end
            end
            @(negedge clock);
            got = {ia.data_ready, frame_a, sclk_a, so_a, done_a};
            checks++;
            if (got !== 5'b10000) begin
                errors++;
                $display("FAIL noise_idle word=%h got %b exp %b", w, got, 5'b10000);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] w = $urandom;
        logic [31:0] w2 = 32'h8000_0000;
        logic [4:0] got, exp;
        ia.data_in = w;
        ia.data_valid = 1'b1;
        for (int j = 0; j <= 40; j++) begin
            @(negedge clock);
            if (j == 0) ia.data_valid = 1'b0;
            got = {frame_a, sclk_a, so_a, done_a, ia.data_ready};
            exp = {1'b1, ref_sclk(4, j), ref_bit(w, 32, 4, 1'b1, j), 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pre_reset j=%0d got %b exp %b", j, got, exp);
            end
        end
        reset_n = 1'b0;
        #1;
        got = {ia.data_ready, frame_a, sclk_a, so_a, done_a};
        checks++;
        if (got !== 5'b10000) begin
            errors++;
            $display("FAIL async_reset got %b exp %b", got, 5'b10000);
        end
        for (int i = 0; i < 2; i++) begin
            ia.data_in = $urandom;
            ia.data_valid = 1'b1;
            @(negedge clock);
            got = {ia.data_ready, frame_a, sclk_a, so_a, done_a};
            checks++;
            if (got !== 5'b10000) begin
                errors++;
                $display("FAIL reset_hold cycle=%0d got %b exp %b", i, got, 5'b10000);
            end
        end
        ia.data_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        got = {ia.data_ready, frame_a, sclk_a, so_a, done_a};
        checks++;
        if (got !== 5'b10000) begin
            errors++;
            $display("FAIL post_reset_idle got %b exp %b", got, 5'b10000);
        end
        ia.data_in = w2;
        ia.data_valid = 1'b1;
        for (int j = 0; j < 128; j++) begin
            @(negedge clock);
            if (j == 0) ia.data_valid = 1'b0;
            got = {frame_a, sclk_a, so_a, done_a, ia.data_ready};
            exp = {1'b1, ref_sclk(4, j), ref_bit(w2, 32, 4, 1'b1, j), j == 127, j == 127};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL post_reset_word j=%0d got %b exp %b", j, got, exp);
            end
        end
        @(negedge clock);
        got = {ia.data_ready, frame_a, sclk_a, so_a, done_a};
        checks++;
        if (got !== 5'b10000) begin
            errors++;
            $display("FAIL post_reset_final_idle got %b exp %b", got, 5'b10000);
        end
    endtask

    initial begin
        ia.data_in = '0;
        ia.data_valid = 1'b0;
        ib.data_in = '0;
        ib.data_valid = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_lsb_first();
        test_mid_word_noise();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
